// File: rtl/load_store_buffer_pkg.sv
// Shared widths, funct3 codes, FSM states and queue entry layout
// for the load/store buffer. Optional: LSB_MMIO_ORDER_EN.
package load_store_buffer_pkg;

  localparam int DATA_W    = 32;
  localparam int ROB_POS_W = 4;
  localparam int LSB_SIZE  = 16;
  localparam int LSB_POS_W = $clog2(LSB_SIZE);

  localparam logic [LSB_POS_W:0] LSB_FULL =
    (LSB_POS_W + 1)'(LSB_SIZE);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int         IO_HI    = 17;
  localparam int         IO_LO    = 16;
  localparam logic [1:0] IO_SPACE = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } lsb_state_t;

  typedef struct packed {
    logic [ROB_POS_W-1:0] rob_pos;
    logic                 is_store;
    logic [2:0]           funct3;
    logic                 rs1_rdy;
    logic [DATA_W-1:0]    rs1_val;
    logic [ROB_POS_W-1:0] rs1_tag;
    logic                 rs2_rdy;
    logic [DATA_W-1:0]    rs2_val;
    logic [ROB_POS_W-1:0] rs2_tag;
    logic [DATA_W-1:0]    imm;
    logic                 committed;
  } lsb_entry_t;

  function automatic logic [2:0] mem_len(
    input logic [1:0] sz
  );
    unique case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Returns {ready, value} after snooping both result buses.
  function automatic logic [DATA_W:0] snoop(
    input logic                 rdy,
    input logic [DATA_W-1:0]    val,
    input logic [ROB_POS_W-1:0] tag,
    input logic                 a_v,
    input logic [ROB_POS_W-1:0] a_pos,
    input logic [DATA_W-1:0]    a_val,
    input logic                 l_v,
    input logic [ROB_POS_W-1:0] l_pos,
    input logic [DATA_W-1:0]    l_val
  );
    if (!rdy && a_v && tag == a_pos)
      return {1'b1, a_val};
    if (!rdy && l_v && tag == l_pos)
      return {1'b1, l_val};
    return {rdy, val};
  endfunction

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// Sign/zero extension of memory read data by load funct3.
// Purely combinational.
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] val
);

  always_comb begin
    val = r_data;
    unique case (funct3)
      F3_LB:
        val = {{(DATA_W-8){r_data[7]}}, r_data[7:0]};
      F3_LH:
        val = {{(DATA_W-16){r_data[15]}}, r_data[15:0]};
      F3_LBU:
        val = {{(DATA_W-8){1'b0}}, r_data[7:0]};
      F3_LHU:
        val = {{(DATA_W-16){1'b0}}, r_data[15:0]};
      default:
        val = r_data;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue feeding the memory controller.
// Optional: LSB_MMIO_ORDER_EN holds IO loads until ROB head.
module load_store_buffer
  import load_store_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  output logic                 lsb_nxt_full,
  input  logic                 issue,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 issue_is_store,
  input  logic [2:0]           issue_funct3,
  input  logic                 issue_rs1_rdy,
  input  logic                 issue_rs2_rdy,
  input  logic [DATA_W-1:0]    issue_rs1_val,
  input  logic [DATA_W-1:0]    issue_rs2_val,
  input  logic [ROB_POS_W-1:0] issue_rs1_tag,
  input  logic [ROB_POS_W-1:0] issue_rs2_tag,
  input  logic [DATA_W-1:0]    issue_imm,
  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [DATA_W-1:0]    alu_result_val,
  input  logic                 commit_store,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [ROB_POS_W-1:0] rob_head_pos,
  output logic                 mc_en,
  output logic                 mc_wr,
  output logic [DATA_W-1:0]    mc_addr,
  output logic [2:0]           mc_len,
  output logic [DATA_W-1:0]    mc_w_data,
  input  logic                 mc_done,
  input  logic [DATA_W-1:0]    mc_r_data,
  output logic                 lsb_result,
  output logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  output logic [DATA_W-1:0]    lsb_result_val
);

  localparam int CW = LSB_POS_W + 1;

  lsb_entry_t           q [LSB_SIZE];
  lsb_entry_t           ne;
  lsb_state_t           state;
  logic [LSB_POS_W-1:0] head, tail, head_n, tail_n;
  logic [CW-1:0]        count, cc, count_n, cc_n;
  logic                 kill, launch, pop, issue_ok;
  logic                 keep, commit_inc, io_block;
  logic [LSB_SIZE-1:0]  commit_hit;
  logic [DATA_W-1:0]    addr, ext;

  assign addr = q[head].rs1_val + q[head].imm;

`ifdef LSB_MMIO_ORDER_EN
  assign io_block = !q[head].is_store &&
                    addr[IO_HI:IO_LO] == IO_SPACE &&
                    q[head].rob_pos != rob_head_pos;
`else
  logic unused_head;
  assign unused_head = ^rob_head_pos;
  assign io_block    = 1'b0;
`endif

  lsb_load_extend u_ext (
    .funct3 (q[head].funct3),
    .r_data (mc_r_data),
    .val    (ext)
  );

  always_comb begin
    ne         = '0;
    ne.rob_pos  = issue_rob_pos;
    ne.is_store = issue_is_store;
    ne.funct3   = issue_funct3;
    ne.rs1_tag  = issue_rs1_tag;
    ne.rs2_tag  = issue_rs2_tag;
    ne.imm      = issue_imm;
    {ne.rs1_rdy, ne.rs1_val} = snoop(
      issue_rs1_rdy, issue_rs1_val, issue_rs1_tag,
      alu_result, alu_result_rob_pos, alu_result_val,
      lsb_result, lsb_result_rob_pos, lsb_result_val);
    {ne.rs2_rdy, ne.rs2_val} = snoop(
      issue_rs2_rdy, issue_rs2_val, issue_rs2_tag,
      alu_result, alu_result_rob_pos, alu_result_val,
      lsb_result, lsb_result_rob_pos, lsb_result_val);
  end

  always_comb begin
    for (int i = 0; i < LSB_SIZE; i++)
      commit_hit[i] = commit_store &&
        ({1'b0, LSB_POS_W'(i) - head} < count) &&
        q[i].is_store && !q[i].committed &&
        q[i].rob_pos == commit_rob_pos;
    commit_inc = |commit_hit;
  end

  always_comb begin
    launch = rdy && state == IDLE && count != '0 &&
             q[head].rs1_rdy && q[head].rs2_rdy &&
             !io_block &&
             (q[head].is_store ? q[head].committed
                               : !rollback);
    pop      = rdy && state == WAIT_MEM && mc_done;
    issue_ok = rdy && issue && !rollback &&
               (count != LSB_FULL || pop);
    // An unfinished load stays queued so its done can pop it.
    keep   = state == WAIT_MEM && !q[head].is_store && !mc_done;
    head_n = head + LSB_POS_W'(pop);
    cc_n   = cc + CW'(commit_inc) -
             CW'(pop && q[head].is_store);
    if (rollback) begin
      count_n = cc_n + CW'(keep);
      tail_n  = head_n + count_n[LSB_POS_W-1:0];
    end else begin
      count_n = count + CW'(issue_ok) - CW'(pop);
      tail_n  = tail + LSB_POS_W'(issue_ok);
    end
  end

  assign lsb_nxt_full =
    (count + CW'(issue_ok) - CW'(pop)) == LSB_FULL;

  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        {q[i].rs1_rdy, q[i].rs1_val} <= snoop(
          q[i].rs1_rdy, q[i].rs1_val, q[i].rs1_tag,
          alu_result, alu_result_rob_pos, alu_result_val,
          lsb_result, lsb_result_rob_pos, lsb_result_val);
        {q[i].rs2_rdy, q[i].rs2_val} <= snoop(
          q[i].rs2_rdy, q[i].rs2_val, q[i].rs2_tag,
          alu_result, alu_result_rob_pos, alu_result_val,
          lsb_result, lsb_result_rob_pos, lsb_result_val);
        if (commit_hit[i])
          q[i].committed <= 1'b1;
      end
      if (issue_ok)
        q[tail] <= ne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      cc                 <= '0;
      state              <= IDLE;
      kill               <= 1'b0;
      mc_en              <= 1'b0;
      mc_wr              <= 1'b0;
      mc_addr            <= '0;
      mc_len             <= '0;
      mc_w_data          <= '0;
      lsb_result         <= 1'b0;
      lsb_result_rob_pos <= '0;
      lsb_result_val     <= '0;
    end else if (rdy) begin
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
      cc         <= cc_n;
      lsb_result <= 1'b0;
      unique case (state)
        IDLE: if (launch) begin
          state     <= WAIT_MEM;
          mc_en     <= 1'b1;
          mc_wr     <= q[head].is_store;
          mc_addr   <= addr;
          mc_len    <= mem_len(q[head].funct3[1:0]);
          mc_w_data <= q[head].rs2_val;
        end
        WAIT_MEM: if (mc_done) begin
          state              <= IDLE;
          mc_en              <= 1'b0;
          mc_wr              <= 1'b0;
          kill               <= 1'b0;
          lsb_result         <= q[head].is_store ||
                                (!kill && !rollback);
          lsb_result_rob_pos <= q[head].rob_pos;
          lsb_result_val     <= q[head].is_store ? '0 : ext;
        end else if (rollback && !q[head].is_store) begin
          kill <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed self-checking bench for load_store_buffer.
// Covers MMIO ordering when LSB_MMIO_ORDER_EN is defined.
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  logic        clk = 0;
  logic        rst = 0;
  logic        rdy = 1;
  logic        rollback = 0;
  logic        lsb_nxt_full;
  logic        issue = 0;
  logic [3:0]  issue_rob_pos = 0;
  logic        issue_is_store = 0;
  logic [2:0]  issue_funct3 = 0;
  logic        issue_rs1_rdy = 0, issue_rs2_rdy = 0;
  logic [31:0] issue_rs1_val = 0, issue_rs2_val = 0;
  logic [3:0]  issue_rs1_tag = 0, issue_rs2_tag = 0;
  logic [31:0] issue_imm = 0;
  logic        alu_result = 0;
  logic [3:0]  alu_result_rob_pos = 0;
  logic [31:0] alu_result_val = 0;
  logic        commit_store = 0;
  logic [3:0]  commit_rob_pos = 0;
  logic [3:0]  rob_head_pos = 0;
  logic        mc_en, mc_wr;
  logic [31:0] mc_addr, mc_w_data;
  logic [2:0]  mc_len;
  logic        mc_done = 0;
  logic [31:0] mc_r_data = 0;
  logic        lsb_result;
  logic [3:0]  lsb_result_rob_pos;
  logic [31:0] lsb_result_val;

  int checks = 0;
  int errors = 0;
  logic seen;

  load_store_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .lsb_nxt_full(lsb_nxt_full),
    .issue(issue), .issue_rob_pos(issue_rob_pos),
    .issue_is_store(issue_is_store),
    .issue_funct3(issue_funct3),
    .issue_rs1_rdy(issue_rs1_rdy),
    .issue_rs2_rdy(issue_rs2_rdy),
    .issue_rs1_val(issue_rs1_val),
    .issue_rs2_val(issue_rs2_val),
    .issue_rs1_tag(issue_rs1_tag),
    .issue_rs2_tag(issue_rs2_tag),
    .issue_imm(issue_imm),
    .alu_result(alu_result),
    .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .commit_store(commit_store),
    .commit_rob_pos(commit_rob_pos),
    .rob_head_pos(rob_head_pos),
    .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr),
    .mc_len(mc_len), .mc_w_data(mc_w_data),
    .mc_done(mc_done), .mc_r_data(mc_r_data),
    .lsb_result(lsb_result),
    .lsb_result_rob_pos(lsb_result_rob_pos),
    .lsb_result_val(lsb_result_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] pos,
                           input logic st,
                           input logic [2:0] f3,
                           input logic r1,
                           input logic [31:0] v1,
                           input logic [3:0] t1,
                           input logic [31:0] v2,
                           input logic [31:0] imm);
    issue          = 1;
    issue_rob_pos  = pos;
    issue_is_store = st;
    issue_funct3   = f3;
    issue_rs1_rdy  = r1;
    issue_rs1_val  = v1;
    issue_rs1_tag  = t1;
    issue_rs2_rdy  = 1;
    issue_rs2_val  = v2;
    issue_rs2_tag  = 0;
    issue_imm      = imm;
  endtask

  task automatic issue_op(input logic [3:0] pos,
                          input logic st,
                          input logic [2:0] f3,
                          input logic r1,
                          input logic [31:0] v1,
                          input logic [3:0] t1,
                          input logic [31:0] v2,
                          input logic [31:0] imm);
    set_issue(pos, st, f3, r1, v1, t1, v2, imm);
    tick();
    issue = 0;
  endtask

  task automatic wait_mc(input string tag);
    for (int k = 0; k < 50 && mc_en !== 1'b1; k++)
      tick();
    check(tag, 32'(mc_en), 1);
  endtask

  task automatic mem_done(input logic [31:0] d);
    mc_done   = 1;
    mc_r_data = d;
    tick();
    mc_done = 0;
  endtask

  task automatic idle_watch(input int n);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      seen = seen | mc_en | lsb_result;
    end
  endtask

  logic [2:0]  ld_f3  [5];
  logic [31:0] ld_dat [5];
  logic [31:0] ld_exp [5];
  logic [2:0]  ld_len [5];

  initial begin
    ld_f3[0] = F3_LB;  ld_dat[0] = 32'h1234_5680;
    ld_exp[0] = 32'hFFFF_FF80; ld_len[0] = 3'd1;
    ld_f3[1] = F3_LBU; ld_dat[1] = 32'h1234_5680;
    ld_exp[1] = 32'h0000_0080; ld_len[1] = 3'd1;
    ld_f3[2] = F3_LH;  ld_dat[2] = 32'h1234_8001;
    ld_exp[2] = 32'hFFFF_8001; ld_len[2] = 3'd2;
    ld_f3[3] = F3_LHU; ld_dat[3] = 32'h1234_8001;
    ld_exp[3] = 32'h0000_8001; ld_len[3] = 3'd2;
    ld_f3[4] = F3_LW;  ld_dat[4] = 32'h0000_0080;
    ld_exp[4] = 32'h0000_0080; ld_len[4] = 3'd4;

    tick(); tick();
    check("rst_mc_en", 32'(mc_en), 0);
    check("rst_result", 32'(lsb_result), 0);
    check("rst_full", 32'(lsb_nxt_full), 0);
    check("rst_addr", mc_addr, 0);
    rst = 1;
    tick();

    issue_op(4'd1, 0, F3_LW, 1, 32'h1000, 0, 0, 4);
    wait_mc("lw_launch");
    check("lw_addr", mc_addr, 32'h1004);
    check("lw_len", 32'(mc_len), 4);
    check("lw_wr", 32'(mc_wr), 0);
    tick(); tick(); tick();
    check("lw_hold_en", 32'(mc_en), 1);
    check("lw_hold_addr", mc_addr, 32'h1004);
    mem_done(32'hDEAD_BEEF);
    check("lw_res", 32'(lsb_result), 1);
    check("lw_pos", 32'(lsb_result_rob_pos), 1);
    check("lw_val", lsb_result_val, 32'hDEAD_BEEF);
    tick();
    check("lw_pulse1", 32'(lsb_result), 0);
    check("lw_en_off", 32'(mc_en), 0);

    for (int i = 0; i < 5; i++) begin
      issue_op(4'(i + 2), 0, ld_f3[i], 1, 32'h10, 0, 0, 0);
      wait_mc("ext_launch");
      check("ext_len", 32'(mc_len), 32'(ld_len[i]));
      mem_done(ld_dat[i]);
      check("ext_val", lsb_result_val, ld_exp[i]);
      tick();
    end

    issue_op(4'd3, 1, F3_SW, 1, 32'h3000, 0,
             32'h0000_CAFE, 8);
    idle_watch(10);
    check("sw_uncommitted", 32'(seen), 0);
    commit_store   = 1;
    commit_rob_pos = 4'd3;
    tick();
    commit_store = 0;
    tick();
    check("sw_launch", 32'(mc_en), 1);
    check("sw_wr", 32'(mc_wr), 1);
    check("sw_addr", mc_addr, 32'h3008);
    check("sw_wdata", mc_w_data, 32'h0000_CAFE);
    mem_done(32'h1234_5678);
    check("sw_res", 32'(lsb_result), 1);
    check("sw_val", lsb_result_val, 0);
    tick();

    issue_op(4'd6, 0, F3_LW, 0, 0, 4'd5, 0, 0);
    idle_watch(3);
    check("snoop_wait", 32'(seen), 0);
    alu_result         = 1;
    alu_result_rob_pos = 4'd5;
    alu_result_val     = 32'h2000;
    tick();
    alu_result = 0;
    wait_mc("snoop_launch");
    check("snoop_addr", mc_addr, 32'h2000);
    mem_done(0);
    tick();

    set_issue(4'd7, 0, F3_LW, 0, 0, 4'd8, 0, 0);
    alu_result         = 1;
    alu_result_rob_pos = 4'd8;
    alu_result_val     = 32'h2400;
    tick();
    issue = 0;
    alu_result = 0;
    wait_mc("issue_snoop_launch");
    check("issue_snoop_addr", mc_addr, 32'h2400);
    mem_done(0);
    tick();

    issue_op(4'd9, 1, F3_SW, 1, 32'h4000, 0, 32'h77, 0);
    issue_op(4'd10, 0, F3_LW, 1, 32'h100, 0, 0, 0);
    issue_op(4'd11, 0, F3_LW, 1, 32'h104, 0, 0, 0);
    issue_op(4'd12, 0, F3_LW, 1, 32'h108, 0, 0, 0);
    commit_store   = 1;
    commit_rob_pos = 4'd9;
    tick();
    commit_store = 0;
    wait_mc("rb_sw_launch");
    check("rb_sw_wr", 32'(mc_wr), 1);
    rollback = 1;
    tick();
    rollback = 0;
    check("rb_sw_hold", 32'(mc_en), 1);
    mem_done(0);
    check("rb_sw_res", 32'(lsb_result), 1);
    check("rb_sw_pos", 32'(lsb_result_rob_pos), 9);
    idle_watch(10);
    check("rb_no_loads", 32'(seen), 0);

    issue_op(4'd13, 0, F3_LW, 1, 32'h200, 0, 0, 0);
    wait_mc("kill_launch");
    rollback = 1;
    tick();
    rollback = 0;
    tick(); tick();
    check("kill_hold", 32'(mc_en), 1);
    mem_done(32'h99);
    check("kill_res", 32'(lsb_result), 0);
    idle_watch(5);
    check("kill_idle", 32'(seen), 0);

    for (int i = 0; i < 16; i++) begin
      set_issue(4'(i), 0, F3_LW, 0, 0, 4'd15, 0, 0);
      #1;
      if (i == 14) check("fill_15", 32'(lsb_nxt_full), 0);
      if (i == 15) check("fill_16", 32'(lsb_nxt_full), 1);
      tick();
    end
    issue = 0;
    #1;
    check("full_hold", 32'(lsb_nxt_full), 1);
    alu_result         = 1;
    alu_result_rob_pos = 4'd15;
    alu_result_val     = 32'h5000;
    tick();
    alu_result = 0;
    wait_mc("full_launch");
    check("full_addr", mc_addr, 32'h5000);
    set_issue(4'd14, 0, F3_LW, 1, 32'h6000, 0, 0, 0);
    mc_done   = 1;
    mc_r_data = 32'h11;
    #1;
    check("full_swap", 32'(lsb_nxt_full), 1);
    tick();
    issue   = 0;
    mc_done = 0;
    check("full_pop_res", 32'(lsb_result), 1);
    check("full_pop_pos", 32'(lsb_result_rob_pos), 0);
    rollback = 1;
    tick();
    rollback = 0;
    check("flush_full", 32'(lsb_nxt_full), 0);
    check("flush_en", 32'(mc_en), 0);
    idle_watch(5);
    check("flush_idle", 32'(seen), 0);

    issue_op(4'd2, 0, F3_LW, 1, 32'h700, 0, 0, 0);
    wait_mc("rdy_launch");
    rdy       = 0;
    mc_done   = 1;
    mc_r_data = 32'h55;
    tick(); tick(); tick();
    check("rdy_hold_res", 32'(lsb_result), 0);
    check("rdy_hold_en", 32'(mc_en), 1);
    rdy = 1;
    tick();
    mc_done = 0;
    check("rdy_res", 32'(lsb_result), 1);
    check("rdy_val", lsb_result_val, 32'h55);
    tick();

    issue_op(4'd4, 0, F3_LW, 1, 32'h800, 0, 0, 0);
    wait_mc("arst_launch");
    #3;
    rst = 0;
    #1;
    check("arst_en", 32'(mc_en), 0);
    check("arst_res", 32'(lsb_result), 0);
    check("arst_full", 32'(lsb_nxt_full), 0);
    check("arst_addr", mc_addr, 0);
    #1;
    rst = 1;
    idle_watch(5);
    check("arst_idle", 32'(seen), 0);

`ifdef LSB_MMIO_ORDER_EN
    rob_head_pos = 4'd2;
    issue_op(4'd4, 0, F3_LW, 1, 32'h30000, 0, 0, 0);
    idle_watch(6);
    check("mmio_block", 32'(seen), 0);
    rob_head_pos = 4'd4;
    wait_mc("mmio_launch");
    check("mmio_addr", mc_addr, 32'h30000);
    mem_done(32'h42);
    check("mmio_val", lsb_result_val, 32'h42);
    rob_head_pos = 4'd0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
